// File: rtl/pattern_match_mux_pkg.sv
// ============================================================================
// Module   : pmm_pkg
// Purpose  : Shared types, constants and helpers for pattern_match_mux.
//            Table keys are stored zero-extended to KEY_W_MAX bits so that a
//            single entry struct serves every KEY_W <= KEY_W_MAX. The unused
//            upper bits are constant zero and optimise away.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pmm_pkg;

  localparam int MISS_CNT_W = 16;
  localparam int KEY_W_MAX  = 1024;

  // Index width for n channels, never narrower than one bit.
  function automatic int IDX_W(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 en;
    logic [KEY_W_MAX-1:0] key;
  } pmm_entry_t;

endpackage

`default_nettype wire

// File: rtl/pattern_match_mux_if.sv
// ============================================================================
// Module   : pattern_match_mux_if
// Purpose  : Configuration, key-input and result bus of pattern_match_mux.
//            master = key source / consumer side, slave = the selector.
//            miss_cnt exists only when PMM_MISS_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pattern_match_mux_if #(
  parameter int NUM_CH = 4,
  parameter int KEY_W  = 260,
  parameter int DATA_W = 1
) ();
  import pmm_pkg::*;

  localparam int IW = IDX_W(NUM_CH);

  logic                     cfg_we;
  logic [IW-1:0]            cfg_idx;
  logic [KEY_W-1:0]         cfg_key;
  logic                     cfg_en;
  logic                     in_valid;
  logic                     in_ready;
  logic [KEY_W-1:0]         in_key;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_hit;
  logic [IW-1:0]            out_idx;
  logic                     miss_sticky;
`ifdef PMM_MISS_CNT_EN
  logic [MISS_CNT_W-1:0]    miss_cnt;
`endif

  modport master (
    output cfg_we, cfg_idx, cfg_key, cfg_en, in_valid, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_hit, out_idx, miss_sticky
`ifdef PMM_MISS_CNT_EN
    , input miss_cnt
`endif
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_key, cfg_en, in_valid, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data, out_hit, out_idx, miss_sticky
`ifdef PMM_MISS_CNT_EN
    , output miss_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/pattern_match_mux_prio_enc.sv
// ============================================================================
// Module   : pmm_prio_enc
// Purpose  : Lowest-index-wins request vector to binary index encoder with a
//            hit flag. Index is 0 when no request is set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pmm_prio_enc
  import pmm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req_i,
  output logic [IDX_W(N)-1:0] idx_o,
  output logic                hit_o
);

  localparam int IW = IDX_W(N);

  // Scan from the top down so the lowest set request is the last one written.
  always_comb begin
    idx_o = '0;
    hit_o = |req_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_match_mux.sv
// ============================================================================
// Module   : pattern_match_mux
// Purpose  : Registered key-match selector. Stage 1 compares the accepted key
//            against a programmable NUM_CH-entry pattern table; stage 2
//            priority-encodes the match vector and forwards the data of the
//            lowest matching channel (DEFAULT_DATA on a miss).
//            Optional: PMM_MISS_CNT_EN adds a saturating delivered-miss count.
//            KEY_W must not exceed pmm_pkg::KEY_W_MAX.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pattern_match_mux
  import pmm_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                KEY_W        = 260,
  parameter int                DATA_W       = 1,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pattern_match_mux_if.slave   bus
);

  localparam int IW = IDX_W(NUM_CH);

  pmm_entry_t               tbl_q [NUM_CH];

  logic                     s1_valid_q;
  logic [NUM_CH-1:0]        s1_match_q;
  logic [NUM_CH*DATA_W-1:0] s1_data_q;

  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_data_q;
  logic                     out_hit_q;
  logic [IW-1:0]            out_idx_q;
  logic                     miss_sticky_q;

  logic [NUM_CH-1:0]        match_d;
  logic [IW-1:0]            enc_idx;
  logic                     enc_hit;
  logic [DATA_W-1:0]        sel_data_d;

  logic                     s2_free;
  logic                     s1_adv;
  logic                     in_ready;
  logic                     accept;

  assign s2_free  = ~out_valid_q | bus.out_ready;
  assign s1_adv   = s1_valid_q & s2_free;
  assign in_ready = ~s1_valid_q | s2_free;
  assign accept   = bus.in_valid & in_ready;

  // Pattern table; a write lands at the edge, so a same-cycle compare sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) tbl_q[i] <= '0;
    end else if (bus.cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.cfg_idx == IW'(i)) begin
          tbl_q[i].en  <= bus.cfg_en;
          tbl_q[i].key <= KEY_W_MAX'(bus.cfg_key);
        end
      end
    end
  end

  // Per-entry compare of the offered key against the current table.
  always_comb begin
    match_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      match_d[i] = tbl_q[i].en & (KEY_W_MAX'(bus.in_key) == tbl_q[i].key);
    end
  end

  // Stage 1: capture match vector and channel data on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
      s1_data_q  <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_match_q <= match_d;
      s1_data_q  <= bus.in_data;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  pmm_prio_enc #(.N(NUM_CH)) u_prio_enc (
    .req_i (s1_match_q),
    .idx_o (enc_idx),
    .hit_o (enc_hit)
  );

  assign sel_data_d = enc_hit ? s1_data_q[int'(enc_idx) * DATA_W +: DATA_W] : DEFAULT_DATA;

  // Stage 2: registered result, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= DEFAULT_DATA;
      out_hit_q     <= 1'b0;
      out_idx_q     <= '0;
      miss_sticky_q <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data_d;
      out_hit_q   <= enc_hit;
      out_idx_q   <= enc_idx;
      if (!enc_hit) miss_sticky_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PMM_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt_q;

  // Count delivered misses, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && !out_hit_q && (miss_cnt_q != '1)) begin
      miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign bus.miss_cnt = miss_cnt_q;
`endif

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_hit     = out_hit_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.miss_sticky = miss_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_match_mux.sv
// ============================================================================
// Module   : tb_pattern_match_mux
// Purpose  : Self-checking bench for pattern_match_mux. A reference table
//            model predicts each accepted key's result into a queue; the
//            monitor pops and compares on every delivered result.
//            Miss-counter scenarios run when PMM_MISS_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pattern_match_mux;
  import pmm_pkg::*;

  localparam int NUM_CH = 4;
  localparam int KEY_W  = 260;
  localparam int DATA_W = 1;
  localparam logic [DATA_W-1:0] DEF = 1'b1;
  localparam int IW = IDX_W(NUM_CH);

  typedef logic [KEY_W-1:0] key_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              hit;
    logic [IW-1:0]     idx;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_match_mux_if #(.NUM_CH(NUM_CH), .KEY_W(KEY_W), .DATA_W(DATA_W)) bus ();

  pattern_match_mux #(
    .NUM_CH(NUM_CH), .KEY_W(KEY_W), .DATA_W(DATA_W), .DEFAULT_DATA(DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   delivered = 0;
  logic m_en [NUM_CH];
  key_t m_key [NUM_CH];
  res_t mon_got, mon_exp;

  // Scoreboard: compare delivered results, predict accepted keys, track table writes.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < NUM_CH; i++) begin
        m_en[i]  = 1'b0;
        m_key[i] = '0;
      end
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        mon_got = '{data: bus.out_data, hit: bus.out_hit, idx: bus.out_idx};
        checks++;
        delivered++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got data=%0h hit=%0b idx=%0d, required no output", mon_got.data, mon_got.hit, mon_got.idx);
        end else begin
          mon_exp = sbq.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL sb_result: got data=%0h hit=%0b idx=%0d, required data=%0h hit=%0b idx=%0d",
                     mon_got.data, mon_got.hit, mon_got.idx, mon_exp.data, mon_exp.hit, mon_exp.idx);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_exp = '{data: DEF, hit: 1'b0, idx: '0};
        for (int i = 0; i < NUM_CH; i++) begin
          if (!mon_exp.hit && m_en[i] && (m_key[i] == bus.in_key)) begin
            mon_exp.hit  = 1'b1;
            mon_exp.idx  = IW'(i);
            mon_exp.data = bus.in_data[i*DATA_W +: DATA_W];
          end
        end
        sbq.push_back(mon_exp);
      end
      if (bus.cfg_we) begin
        m_en[bus.cfg_idx]  = bus.cfg_en;
        m_key[bus.cfg_idx] = bus.cfg_key;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input key_t key, input logic en);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = IW'(idx);
    bus.cfg_key = key;
    bus.cfg_en  = en;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic program_std();
    cfg_write(0, 260'h0, 1'b1);
    cfg_write(1, 260'hF, 1'b1);
    cfg_write(2, 260'hFF, 1'b1);
    cfg_write(3, 260'hFFFF, 1'b1);
  endtask

  // Offer keys one per cycle, waiting (bounded) while the block is not ready.
  task automatic send_keys(input key_t keys[$], input logic [NUM_CH*DATA_W-1:0] data);
    int guard;
    foreach (keys[k]) begin
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_key   = keys[k];
      bus.in_data  = data;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, guard);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sbq.size() != 0 || bus.out_valid) && guard < 50) begin
      @(posedge clk);
      #1 guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d out_valid=%0b, required 0/0", sbq.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_key = '0; bus.cfg_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_key = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    do_reset();
    checks += 6;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b required 1", bus.in_ready); end
    if (bus.out_data !== DEF) begin errors++; $display("FAIL rst_out_data: got %0h required %0h", bus.out_data, DEF); end
    if (bus.out_hit !== 1'b0) begin errors++; $display("FAIL rst_out_hit: got %0b required 0", bus.out_hit); end
    if (bus.out_idx !== '0) begin errors++; $display("FAIL rst_out_idx: got %0d required 0", bus.out_idx); end
    if (bus.miss_sticky !== 1'b0) begin errors++; $display("FAIL rst_miss_sticky: got %0b required 0", bus.miss_sticky); end
  endtask

  task automatic test_miss_latency();
    bus.in_valid = 1'b1;
    bus.in_key   = '0;
    bus.in_data  = 4'b1010;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_t1: out_valid got %0b required 0", bus.out_valid); end
    @(posedge clk);
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_t2: out_valid got %0b required 1", bus.out_valid); end
    if (bus.miss_sticky !== 1'b1) begin errors++; $display("FAIL miss_sticky: got %0b required 1", bus.miss_sticky); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    key_t q[$];
    int   d0;
    program_std();
    q.push_back(260'h0); q.push_back(260'hF); q.push_back(260'hFF); q.push_back(260'hFFFF);
    d0 = delivered;
    send_keys(q, 4'b1010);
    checks++;
    if (delivered - d0 != 2) begin errors++; $display("FAIL b2b_early: delivered %0d required 2", delivered - d0); end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble: out_valid got %0b required 1", bus.out_valid); end
    end
    wait_drain();
    checks++;
    if (delivered - d0 != 4) begin errors++; $display("FAIL b2b_count: delivered %0d required 4", delivered - d0); end
  endtask

  task automatic test_priority();
    key_t q[$];
    cfg_write(1, 260'hAB, 1'b1);
    cfg_write(3, 260'hAB, 1'b1);
    q.push_back(260'hAB);
    send_keys(q, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (bus.out_idx !== 2'd1) begin errors++; $display("FAIL prio_idx: got %0d required 1", bus.out_idx); end
    if (bus.out_hit !== 1'b1) begin errors++; $display("FAIL prio_hit: got %0b required 1", bus.out_hit); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    key_t keys[5];
    key_t rest[$];
    int   acc, d0;
    logic acc_now, have_snap;
    res_t snap, cur;
    keys[0] = 260'hFF; keys[1] = 260'h0; keys[2] = 260'h123; keys[3] = 260'hAB; keys[4] = 260'hFFFF;
    d0 = delivered; acc = 0; have_snap = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_key    = keys[0];
    bus.in_data   = 4'b0110;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      acc_now = bus.in_ready;
      if (bus.out_valid) begin
        cur = '{data: bus.out_data, hit: bus.out_hit, idx: bus.out_idx};
        if (have_snap) begin
          checks++;
          if (cur !== snap) begin errors++; $display("FAIL bp_stable: got %0h required %0h", cur, snap); end
        end
        snap = cur;
        have_snap = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        acc++;
        bus.in_key = keys[acc];
      end
    end
    checks += 2;
    if (acc != 2) begin errors++; $display("FAIL bp_accepted: got %0d required 2", acc); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b required 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int k = acc; k < 5; k++) rest.push_back(keys[k]);
    send_keys(rest, 4'b0110);
    wait_drain();
    checks++;
    if (delivered - d0 != 5) begin errors++; $display("FAIL bp_count: delivered %0d required 5", delivered - d0); end
  endtask

  task automatic test_cfg_collision();
    program_std();
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'd2;
    bus.cfg_key  = 260'h1;
    bus.cfg_en   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_key   = 260'hFF;
    bus.in_data  = 4'b0100;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks += 2;
    if (bus.out_hit !== 1'b1 || bus.out_idx !== 2'd2) begin
      errors++; $display("FAIL coll_old: got hit=%0b idx=%0d required hit=1 idx=2", bus.out_hit, bus.out_idx);
    end
    @(posedge clk);
    #1;
    if (bus.out_hit !== 1'b0 || bus.out_data !== DEF) begin
      errors++; $display("FAIL coll_new: got hit=%0b data=%0h required hit=0 data=%0h", bus.out_hit, bus.out_data, DEF);
    end
    wait_drain();
  endtask

`ifdef PMM_MISS_CNT_EN
  task automatic test_miss_cnt();
    key_t q[$];
    do_reset();
    checks++;
    if (bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL mc_reset: got %0d required 0", bus.miss_cnt); end
    q.push_back(260'h5); q.push_back(260'h6); q.push_back(260'h7);
    fork
      send_keys(q, 4'b1111);
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (bus.miss_cnt !== 16'd3) begin errors++; $display("FAIL mc_count: got %0d required 3", bus.miss_cnt); end
  endtask

  task automatic test_reset_mid();
    key_t q[$];
    q.push_back(260'h1); q.push_back(260'h2); q.push_back(260'h3); q.push_back(260'h4);
    fork
      send_keys(q, 4'b0000);
      begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b required 0", bus.out_valid); end
        if (bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt: got %0d required 0", bus.miss_cnt); end
        if (bus.miss_sticky !== 1'b0) begin errors++; $display("FAIL rmid_sticky: got %0b required 0", bus.miss_sticky); end
        rst = 1'b0;
      end
    join
    wait_drain();
  endtask
`endif

  initial begin
    test_reset();
    test_miss_latency();
    test_back_to_back();
    test_priority();
    test_backpressure();
    test_cfg_collision();
`ifdef PMM_MISS_CNT_EN
    test_miss_cnt();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
